delay_test_ctrl: RTL and testbench
==================================

DELAY_TEST_CTRL -- requirements
Module: delay_test_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 20, giving the delay counter and result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 20'd500000, giving the per-probe loss limit in tx_clk cycles; legal range is 1 to 2^CW-1.
REQ-003 The block SHALL have port tx_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a test run.
REQ-006 The block SHALL have port num_probes, input, 8 bits: the number of probes in the run, sampled on an accepted start.
REQ-007 The block SHALL have port gap_cycles, input, 16 bits: the idle cycles between probes, sampled on an accepted start.
REQ-008 The block SHALL have port send_req, output, 1 bit: a request to transmit one probe frame.
REQ-009 The block SHALL have port send_ack, input, 1 bit: the transmitter has accepted and sent the frame.
REQ-010 The block SHALL have port frame_caught, input, 1 bit: the echoed probe frame has been received.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a run completes.
REQ-013 The block SHALL have port last_delay, output, CW bits: the delay of the most recently caught probe.
REQ-014 The block SHALL have ports min_delay and max_delay, output, CW bits each: the run's extreme caught delays.
REQ-015 The block SHALL have port probe_count, output, 8 bits: probes completed in the current run, caught or lost.
REQ-016 The block SHALL have port lost_count, output, 8 bits: probes that timed out in the current run.

Function
REQ-017 The state machine SHALL have states IDLE, SEND, WAIT, GAP and DONE.
REQ-018 In IDLE, start SHALL sample num_probes and gap_cycles, clear the statistics, and move to SEND; if num_probes==0 it SHALL move to DONE instead.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 In SEND, send_req SHALL be 1 and held until send_ack; send_ack SHALL clear the delay counter to 0 and move to WAIT.
REQ-021 send_ack SHALL be ignored outside SEND, and send_req SHALL be 0 outside SEND.
REQ-022 In WAIT, the counter SHALL increment each cycle, and frame_caught SHALL record delay = counter+1, so a catch on the first WAIT cycle gives delay 1.
REQ-023 On a catch, the block SHALL update last_delay, update min_delay if smaller, update max_delay if larger, and increment probe_count.
REQ-024 In WAIT, if counter+1==TIMEOUT with no catch, the block SHALL increment lost_count and probe_count and leave last, min and max unchanged.
REQ-025 When a catch and the timeout limit coincide, the catch SHALL win.
REQ-026 The counter SHALL never exceed TIMEOUT and SHALL never wrap.
REQ-027 frame_caught SHALL be ignored outside WAIT, which includes late echoes of lost probes.
REQ-028 After WAIT the block SHALL go to GAP, count gap_cycles idle cycles, then go to SEND if probe_count<num_probes, else to DONE.
REQ-029 With gap_cycles==0, GAP SHALL last exactly one cycle.
REQ-030 DONE SHALL assert done for one cycle and return to IDLE.
REQ-031 busy SHALL be 1 in SEND, WAIT and GAP, and 0 in IDLE and DONE.
REQ-032 The statistics SHALL hold their values after DONE until the next accepted start.
REQ-033 Before any catch, min_delay SHALL read all-ones and max_delay SHALL read 0.

Reset
REQ-034 While reset==0 at a clock edge, the block SHALL go to IDLE.
REQ-035 Reset SHALL set send_req=0, busy=0, done=0, last_delay=0, min_delay=all-ones, max_delay=0, probe_count=0, lost_count=0 and counter=0.
REQ-036 Reset mid-run SHALL abort the run with no done pulse, and send_req SHALL be low on the first cycle after the reset edge.

Structure
REQ-037 Package delay_test_pkg SHALL hold the state enum, the CW default and the TIMEOUT default.
REQ-038 The block SHALL contain one sub-module, delay_probe_counter, holding the clear/enable counter, the TIMEOUT compare and the catch-capture register; the FSM and statistics SHALL stay in the top level.

Verification
REQ-039 Scenario: start with num_probes=1, gap=0; ack at cycle 5; frame_caught 7 cycles after ack -> last=min=max=7, probe_count=1, lost=0, one done pulse.
REQ-040 Scenario: num_probes=3 with catch delays 10, 4, 12 -> min=4, max=12, last=12, done exactly once, busy low after done.
REQ-041 Scenario: TIMEOUT=16, no catch -> lost_count=1 at counter 16, min stays all-ones, max stays 0; a frame_caught in GAP changes nothing.
REQ-042 Scenario: TIMEOUT=16 with the catch on the timeout cycle -> last=16, lost=0.
REQ-043 Scenario: gap_cycles=3 -> exactly 3 idle cycles plus one transition cycle between WAIT exit and the next send_req rise; a start pulse mid-run is ignored.
REQ-044 Scenario: reset=0 in WAIT -> next cycle all outputs at reset values; num_probes=0 start -> done one cycle later with no send_req.

Source files
------------

// File: rtl/delay_test_pkg.sv
// Shared state encoding and parameter defaults for the delay test controller.
package delay_test_pkg;

    localparam int          CW_DEFAULT      = 20;
    localparam logic [19:0] TIMEOUT_DEFAULT = 20'd500000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/delay_probe_counter.sv
// Per-probe delay counter with saturating TIMEOUT compare and catch capture.
module delay_probe_counter #(
    parameter int             CW      = 20,
    parameter logic [CW-1:0]  TIMEOUT = 20'd500000
) (
    input  logic          tx_clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_cap,
    input  logic          i_cap_clr,
    output logic [CW-1:0] o_delay,
    output logic          o_limit,
    output logic [CW-1:0] o_last
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_last;
    logic [CW-1:0] w_delay;

    // A catch in the current WAIT cycle counts that cycle, hence the +1.
    assign w_delay = r_cnt + CW'(1);
    assign o_delay = w_delay;
    assign o_limit = (w_delay == TIMEOUT);
    assign o_last  = r_last;

    always_ff @(posedge tx_clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TIMEOUT)) begin
            r_cnt <= w_delay;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!reset) begin
            r_last <= '0;
        end else if (i_cap_clr) begin
            r_last <= '0;
        end else if (i_cap) begin
            r_last <= w_delay;
        end
    end

endmodule

// File: rtl/delay_test_ctrl.sv
// Round-trip delay test controller: sends probes, times echoes, keeps run statistics.
module delay_test_ctrl
    import delay_test_pkg::*;
#(
    parameter int             CW      = CW_DEFAULT,
    parameter logic [CW-1:0]  TIMEOUT = CW'(TIMEOUT_DEFAULT)
) (
    input  logic          tx_clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    num_probes,
    input  logic [15:0]   gap_cycles,
    output logic          send_req,
    input  logic          send_ack,
    input  logic          frame_caught,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] last_delay,
    output logic [CW-1:0] min_delay,
    output logic [CW-1:0] max_delay,
    output logic [7:0]    probe_count,
    output logic [7:0]    lost_count
);

    state_t        r_state;
    logic [7:0]    r_np;
    logic [15:0]   r_gap;
    logic [15:0]   r_gap_cnt;
    logic [CW-1:0] r_min;
    logic [CW-1:0] r_max;
    logic [7:0]    r_pc;
    logic [7:0]    r_lc;

    logic          w_start_ok;
    logic          w_ack_ok;
    logic          w_in_wait;
    logic          w_catch;
    logic          w_limit;
    logic [CW-1:0] w_delay;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_ack_ok   = (r_state == ST_SEND) && send_ack;
    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_catch    = w_in_wait && frame_caught;

    delay_probe_counter #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .tx_clk    (tx_clk),
        .reset     (reset),
        .i_clr     (w_ack_ok),
        .i_en      (w_in_wait),
        .i_cap     (w_catch),
        .i_cap_clr (w_start_ok),
        .o_delay   (w_delay),
        .o_limit   (w_limit),
        .o_last    (last_delay)
    );

    assign send_req    = (r_state == ST_SEND);
    assign busy        = (r_state == ST_SEND) || (r_state == ST_WAIT) || (r_state == ST_GAP);
    assign done        = (r_state == ST_DONE);
    assign min_delay   = r_min;
    assign max_delay   = r_max;
    assign probe_count = r_pc;
    assign lost_count  = r_lc;

    always_ff @(posedge tx_clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_np      <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_min     <= '1;
            r_max     <= '0;
            r_pc      <= '0;
            r_lc      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_np    <= num_probes;
                        r_gap   <= gap_cycles;
                        r_min   <= '1;
                        r_max   <= '0;
                        r_pc    <= '0;
                        r_lc    <= '0;
                        r_state <= (num_probes == 8'd0) ? ST_DONE : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (send_ack) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A catch on the limit cycle is still a catch, not a loss.
                    if (frame_caught) begin
                        if (w_delay < r_min) r_min <= w_delay;
                        if (w_delay > r_max) r_max <= w_delay;
                        r_pc      <= r_pc + 8'd1;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else if (w_limit) begin
                        r_lc      <= r_lc + 8'd1;
                        r_pc      <= r_pc + 8'd1;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == r_gap) begin
                        r_state <= (r_pc < r_np) ? ST_SEND : ST_DONE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_test_ctrl.sv
// Directed bench for delay_test_ctrl with a per-run expected-statistics scoreboard.
module tb_delay_test_ctrl;

    localparam int CW = 20;
    localparam int TO = 16;

    logic          tx_clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_probes = 8'd0;
    logic [15:0]   gap_cycles = 16'd0;
    logic          send_ack = 1'b0;
    logic          frame_caught = 1'b0;
    logic          send_req;
    logic          busy;
    logic          done;
    logic [CW-1:0] last_delay;
    logic [CW-1:0] min_delay;
    logic [CW-1:0] max_delay;
    logic [7:0]    probe_count;
    logic [7:0]    lost_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [CW-1:0] last;
        logic [CW-1:0] mn;
        logic [CW-1:0] mx;
        logic [7:0]    pc;
        logic [7:0]    lc;
    } exp_t;

    exp_t sb[$];

    delay_test_ctrl #(.CW(CW), .TIMEOUT(20'd16)) dut (
        .tx_clk       (tx_clk),
        .reset        (reset),
        .start        (start),
        .num_probes   (num_probes),
        .gap_cycles   (gap_cycles),
        .send_req     (send_req),
        .send_ack     (send_ack),
        .frame_caught (frame_caught),
        .busy         (busy),
        .done         (done),
        .last_delay   (last_delay),
        .min_delay    (min_delay),
        .max_delay    (max_delay),
        .probe_count  (probe_count),
        .lost_count   (lost_count)
    );

    always #5 tx_clk = ~tx_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected statistics come from the delay list: 0 or >TO means no echo.
    task automatic start_run(input int np, input int gap, input int dl[$]);
        exp_t e;
        e.last = '0; e.mn = '1; e.mx = '0; e.pc = '0; e.lc = '0;
        foreach (dl[i]) begin
            if (dl[i] > 0 && dl[i] <= TO) begin
                e.last = CW'(dl[i]);
                if (CW'(dl[i]) < e.mn) e.mn = CW'(dl[i]);
                if (CW'(dl[i]) > e.mx) e.mx = CW'(dl[i]);
            end else begin
                e.lc = e.lc + 8'd1;
            end
            e.pc = e.pc + 8'd1;
        end
        sb.push_back(e);
        num_probes = np[7:0];
        gap_cycles = gap[15:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic serve(input int d, input int ack_wait, input int lost_before);
        int n = 0;
        while (!send_req && n < 40) begin
            tick();
            n++;
        end
        chk("send_req_rise", 32'(send_req), 32'd1);
        if (!send_req) return;
        if (ack_wait > 0) begin
            repeat (ack_wait) tick();
            chk("send_req_held", 32'(send_req), 32'd1);
        end
        send_ack = 1'b1;
        tick();
        send_ack = 1'b0;
        chk("send_req_drop", 32'(send_req), 32'd0);
        if (d > 0 && d <= TO) begin
            repeat (d - 1) tick();
            frame_caught = 1'b1;
            tick();
            frame_caught = 1'b0;
            chk("last_after_catch", 32'(last_delay), 32'(d));
        end else begin
            repeat (TO - 1) tick();
            chk("lost_before_limit", 32'(lost_count), 32'(lost_before));
            tick();
            chk("lost_at_limit", 32'(lost_count), 32'(lost_before + 1));
        end
    endtask

    task automatic finish_run();
        int n = 0;
        exp_t e;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk("run_last", 32'(last_delay), 32'(e.last));
            chk("run_min", 32'(min_delay), 32'(e.mn));
            chk("run_max", 32'(max_delay), 32'(e.mx));
            chk("run_probes", 32'(probe_count), 32'(e.pc));
            chk("run_lost", 32'(lost_count), 32'(e.lc));
            tick();
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_after_done", 32'(busy), 32'd0);
            repeat (3) tick();
            chk("last_held", 32'(last_delay), 32'(e.last));
            chk("min_held", 32'(min_delay), 32'(e.mn));
        end
    endtask

    initial begin
        int q[$];
        int n;
        int saw_done;

        repeat (3) tick();
        chk("rst_send_req", 32'(send_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(last_delay), 32'd0);
        chk("rst_min", 32'(min_delay), 32'hFFFFF);
        chk("rst_max", 32'(max_delay), 32'd0);
        chk("rst_probes", 32'(probe_count), 32'd0);
        chk("rst_lost", 32'(lost_count), 32'd0);
        reset = 1'b1;
        tick();

        // Single probe, late ack, echo 7 cycles after ack.
        q.delete(); q.push_back(7);
        start_run(1, 0, q);
        chk("busy_in_run", 32'(busy), 32'd1);
        serve(7, 4, 0);
        finish_run();

        // Three probes: min/max/last tracking.
        q.delete(); q.push_back(10); q.push_back(4); q.push_back(12);
        start_run(3, 0, q);
        serve(10, 0, 0);
        serve(4, 1, 0);
        serve(12, 0, 0);
        finish_run();

        // Lost probe, then a late echo during GAP.
        q.delete(); q.push_back(0);
        start_run(1, 3, q);
        serve(0, 0, 0);
        chk("lost_min", 32'(min_delay), 32'hFFFFF);
        chk("lost_max", 32'(max_delay), 32'd0);
        chk("lost_busy_gap", 32'(busy), 32'd1);
        frame_caught = 1'b1;
        tick();
        frame_caught = 1'b0;
        chk("gap_echo_last", 32'(last_delay), 32'd0);
        chk("gap_echo_max", 32'(max_delay), 32'd0);
        chk("gap_echo_probes", 32'(probe_count), 32'd1);
        finish_run();

        // Catch exactly on the limit cycle wins over loss.
        q.delete(); q.push_back(16);
        start_run(1, 0, q);
        serve(16, 0, 0);
        finish_run();

        // Gap of 3 cycles with an ignored start pulse in GAP.
        q.delete(); q.push_back(5); q.push_back(6);
        start_run(2, 3, q);
        serve(5, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!send_req && n < 20) begin
            tick();
            n++;
        end
        chk("gap_len", 32'(n), 32'd4);
        chk("start_ignored", 32'(probe_count), 32'd1);
        serve(6, 0, 0);
        finish_run();

        // Reset in WAIT aborts the run with no done pulse.
        num_probes = 8'd2;
        gap_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_ack = 1'b1;
        tick();
        send_ack = 1'b0;
        repeat (3) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("ar_send_req", 32'(send_req), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_last", 32'(last_delay), 32'd0);
        chk("ar_min", 32'(min_delay), 32'hFFFFF);
        chk("ar_max", 32'(max_delay), 32'd0);
        chk("ar_probes", 32'(probe_count), 32'd0);
        chk("ar_lost", 32'(lost_count), 32'd0);
        saw_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || send_req) saw_done++;
        end
        chk("ar_quiet", 32'(saw_done), 32'd0);

        // Zero-probe run: done one cycle after start, no send_req.
        q.delete();
        start_run(0, 0, q);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_send_req", 32'(send_req), 32'd0);
        finish_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
